// File: rtl/audio_pkg.sv
// Shared audio definitions: limiter FSM states, gain/sample limits and the
// symmetric 24-bit saturation used by both the limiter and the EQ sum path.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_SCALE = 2'd2,
        ST_OUT   = 2'd3
    } lim_state_t;

    // Unity gain in unsigned Q1.15.
    localparam logic [15:0] GAIN_UNITY = 16'h8000;

    // Symmetric sample range: -2^23 is excluded so |x| always fits in 23 bits.
    localparam logic signed [23:0] SAMPLE_MAX = 24'sh7FFFFF;
    localparam logic signed [23:0] SAMPLE_MIN = 24'sh800001;

    // Clamp a wide signed value into the symmetric 24-bit range.
    function automatic logic signed [23:0] sat_s24(input logic signed [47:0] v);
        logic signed [47:0] hi;
        logic signed [47:0] lo;
        hi = 48'(SAMPLE_MAX);
        lo = 48'(SAMPLE_MIN);
        if (v > hi) begin
            return SAMPLE_MAX;
        end else if (v < lo) begin
            return SAMPLE_MIN;
        end else begin
            return v[23:0];
        end
    endfunction

endpackage

// File: rtl/limiter_gain_ctrl.sv
// Gain register with fast attack, slow release and a floor. Updates once per
// strobe from the magnitude of the sample just produced.
module limiter_gain_ctrl
    import audio_pkg::*;
#(
    parameter int                GAIN_W        = 16,
    parameter int                MAG_W         = 24,
    parameter logic [MAG_W-1:0]  THRESH        = 24'h600000,
    parameter logic [GAIN_W-1:0] GAIN_MIN      = 16'h1000,
    parameter int                ATTACK_SHIFT  = 2,
    parameter int                RELEASE_SHIFT = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              update,
    input  logic              bypass,
    input  logic [MAG_W-1:0]  mag,
    output logic [GAIN_W-1:0] gain,
    output logic              limiting
);

    localparam logic [GAIN_W-1:0] UNITY = GAIN_UNITY;

    logic [GAIN_W-1:0] gain_reg;
    logic [GAIN_W-1:0] gain_next;
    logic              limiting_reg;
    logic [GAIN_W-1:0] attack_val;
    logic [GAIN_W-1:0] attack_gain;
    logic [GAIN_W-1:0] release_step;
    logic [GAIN_W:0]   release_sum;
    logic [GAIN_W-1:0] release_gain;

    // Candidate gains for attack and release, then pick one on the update strobe.
    always_comb begin
        attack_val   = gain_reg - (gain_reg >> ATTACK_SHIFT);
        attack_gain  = (attack_val < GAIN_MIN) ? GAIN_MIN : attack_val;

        // Release step never rounds to zero, otherwise the gain could stall
        // just below unity.
        release_step = (UNITY - gain_reg) >> RELEASE_SHIFT;
        if (release_step == '0) begin
            release_step = GAIN_W'(1);
        end
        release_sum  = {1'b0, gain_reg} + {1'b0, release_step};
        release_gain = (release_sum > {1'b0, UNITY}) ? UNITY : release_sum[GAIN_W-1:0];

        gain_next = gain_reg;
        if (update) begin
            if (bypass) begin
                gain_next = UNITY;
            end else if (mag > THRESH) begin
                gain_next = attack_gain;
            end else if (gain_reg < UNITY) begin
                gain_next = release_gain;
            end
        end
    end

    // Gain and limiting flag registered together so both change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            gain_reg     <= UNITY;
            limiting_reg <= 1'b0;
        end else begin
            gain_reg     <= gain_next;
            limiting_reg <= (gain_next < UNITY);
        end
    end

    assign gain     = gain_reg;
    assign limiting = limiting_reg;

endmodule

// File: rtl/audio_peak_limiter.sv
// Output peak limiter: sample x gain, round half up, symmetric saturate,
// feedback gain control. Fixed three-cycle latency, one sample in flight.
module audio_peak_limiter
    import audio_pkg::*;
#(
    parameter int                DATA_W        = 24,
    parameter int                GAIN_W        = 16,
    parameter logic [DATA_W-1:0] THRESH        = 24'h600000,
    parameter logic [GAIN_W-1:0] GAIN_MIN      = 16'h1000,
    parameter int                ATTACK_SHIFT  = 2,
    parameter int                RELEASE_SHIFT = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              bypass,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic [GAIN_W-1:0] gain_out,
    output logic              limiting,
    output logic              overrun
);

    // Signed sample times gain widened by a zero sign bit.
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int FRAC_W = GAIN_W - 1;
    localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(1) << (FRAC_W - 1);

    lim_state_t state_reg;
    lim_state_t state_next;

    logic signed [DATA_W-1:0] x_reg;
    logic                     byp_reg;
    logic signed [PROD_W-1:0] prod_reg;
    logic signed [PROD_W-1:0] prod_next;
    logic signed [PROD_W-1:0] round_sum;
    logic signed [PROD_W-1:0] round_shift;
    logic signed [47:0]       round_wide;
    logic signed [DATA_W-1:0] y_next;
    logic [DATA_W-1:0]        mag_next;
    logic [DATA_W-1:0]        mag_reg;
    logic [DATA_W-1:0]        data_out_reg;
    logic                     out_valid_reg;
    logic                     overrun_reg;
    logic [GAIN_W-1:0]        gain_cur;
    logic [GAIN_W-1:0]        gain_eff;
    logic                     gain_update;

    // State register; reset abandons any in-flight sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: only IDLE waits, the other states last exactly one cycle.
    always_comb begin
        state_next  = state_reg;
        gain_update = 1'b0;
        case (state_reg)
            ST_IDLE:  if (in_valid) state_next = ST_MULT;
            ST_MULT:  state_next = ST_SCALE;
            ST_SCALE: state_next = ST_OUT;
            ST_OUT: begin
                state_next  = ST_IDLE;
                gain_update = 1'b1;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Multiply, round and saturate. The saturated value is loaded straight into
    // the output register so out_valid and data_out appear together in OUT.
    always_comb begin
        gain_eff    = byp_reg ? GAIN_UNITY : gain_cur;
        prod_next   = x_reg * $signed({1'b0, gain_eff});
        round_sum   = prod_reg + ROUND_BIAS;
        round_shift = round_sum >>> FRAC_W;
        round_wide  = round_shift;
        y_next      = sat_s24(round_wide);
        mag_next    = y_next[DATA_W-1] ? DATA_W'(-y_next) : y_next;
    end

    // Datapath registers, output strobe and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg         <= '0;
            byp_reg       <= 1'b0;
            prod_reg      <= '0;
            mag_reg       <= '0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            out_valid_reg <= (state_reg == ST_SCALE);
            if (in_valid) begin
                if (state_reg == ST_IDLE) begin
                    x_reg   <= data_in;
                    byp_reg <= bypass;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end
            if (state_reg == ST_MULT) begin
                prod_reg <= prod_next;
            end
            if (state_reg == ST_SCALE) begin
                data_out_reg <= y_next;
                mag_reg      <= mag_next;
            end
        end
    end

    limiter_gain_ctrl #(
        .GAIN_W        (GAIN_W),
        .MAG_W         (DATA_W),
        .THRESH        (THRESH),
        .GAIN_MIN      (GAIN_MIN),
        .ATTACK_SHIFT  (ATTACK_SHIFT),
        .RELEASE_SHIFT (RELEASE_SHIFT)
    ) u_gain_ctrl (
        .clk      (clk),
        .reset    (reset),
        .update   (gain_update),
        .bypass   (byp_reg),
        .mag      (mag_reg),
        .gain     (gain_cur),
        .limiting (limiting)
    );

    assign out_valid = out_valid_reg;
    assign data_out  = data_out_reg;
    assign gain_out  = gain_cur;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_audio_peak_limiter.sv
// Directed bench for audio_peak_limiter with hand-computed expected values.
module tb_audio_peak_limiter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [23:0] data_in;
    logic        bypass;
    logic        out_valid;
    logic [23:0] data_out;
    logic [15:0] gain_out;
    logic        limiting;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    audio_peak_limiter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .bypass    (bypass),
        .out_valid (out_valid),
        .data_out  (data_out),
        .gain_out  (gain_out),
        .limiting  (limiting),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sample through the pipe: strobe at negedge D0, out_valid only at D3,
    // gain and limiting settled at D4.
    task automatic send(input string tag, input logic [23:0] d, input logic byp,
                        input logic [23:0] exp_y, input logic [15:0] exp_g,
                        input logic exp_l);
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = d;
        bypass   = byp;
        @(negedge clk);
        in_valid = 1'b0;
        bypass   = ~byp;
        data_in  = 24'h0;
        check({tag, " ov_d1"}, 48'(out_valid), 48'(1'b0));
        @(negedge clk);
        check({tag, " ov_d2"}, 48'(out_valid), 48'(1'b0));
        @(negedge clk);
        check({tag, " ov_d3"}, 48'(out_valid), 48'(1'b1));
        check({tag, " data"}, 48'(data_out), 48'(exp_y));
        @(negedge clk);
        bypass = 1'b0;
        check({tag, " ov_d4"}, 48'(out_valid), 48'(1'b0));
        check({tag, " hold"}, 48'(data_out), 48'(exp_y));
        check({tag, " gain"}, 48'(gain_out), 48'(exp_g));
        check({tag, " lim"}, 48'(limiting), 48'(exp_l));
        $display("sample %s in=%h byp=%0d out=%h gain=%h lim=%0d",
                 tag, d, byp, data_out, gain_out, limiting);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        data_in  = 24'h0;
        bypass   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst ov", 48'(out_valid), 48'(1'b0));
        check("rst data", 48'(data_out), 48'(24'h0));
        check("rst gain", 48'(gain_out), 48'(16'h8000));
        check("rst lim", 48'(limiting), 48'(1'b0));
        check("rst ovr", 48'(overrun), 48'(1'b0));
        $display("reset values checked");
        reset = 1'b0;

        send("unity",  24'h100000, 1'b0, 24'h100000, 16'h8000, 1'b0);
        send("thresh", 24'h600000, 1'b0, 24'h600000, 16'h8000, 1'b0);
        send("attack", 24'h7FFFFF, 1'b0, 24'h7FFFFF, 16'h6000, 1'b1);
        send("relse1", 24'h7FFFFF, 1'b0, 24'h5FFFFF, 16'h6008, 1'b1);
        send("negrnd", 24'hFFFFFF, 1'b0, 24'hFFFFFF, 16'h600F, 1'b1);
        check("no ovr", 48'(overrun), 48'(1'b0));

        do_reset();
        send("satneg", 24'h800000, 1'b0, 24'h800001, 16'h6000, 1'b1);

        // Overrun: second strobe two cycles after the first is dropped.
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 24'h100000;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = 24'h0;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 24'h200000;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = 24'h0;
        check("ovr ov", 48'(out_valid), 48'(1'b1));
        check("ovr data", 48'(data_out), 48'(24'h0C0000));
        check("ovr flag", 48'(overrun), 48'(1'b1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ovr drop", 48'(out_valid), 48'(1'b0));
        end
        check("ovr gain", 48'(gain_out), 48'(16'h6008));
        check("ovr sticky", 48'(overrun), 48'(1'b1));
        $display("overrun out=%h gain=%h ovr=%0d", data_out, gain_out, overrun);

        // Reset while the sample sits in SCALE.
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 24'h7FFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst ov", 48'(out_valid), 48'(1'b0));
        check("mrst data", 48'(data_out), 48'(24'h0));
        check("mrst gain", 48'(gain_out), 48'(16'h8000));
        check("mrst lim", 48'(limiting), 48'(1'b0));
        check("mrst ovr", 48'(overrun), 48'(1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mrst quiet", 48'(out_valid), 48'(1'b0));
        end
        $display("mid-sample reset out=%h gain=%h ovr=%0d", data_out, gain_out, overrun);

        send("attack2", 24'h7FFFFF, 1'b0, 24'h7FFFFF, 16'h6000, 1'b1);
        send("bypass",  24'h7FFFFF, 1'b1, 24'h7FFFFF, 16'h8000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
